// File: rtl/ascii_frame_sender.sv
// Streams one frame of fixed-width decimal ASCII channel values to a TX FIFO.
// Each channel is converted by sequential shift-add-3, then its digits, separators and line ending are pushed.
module ascii_frame_sender #(
  parameter int         NUM_CH   = 2,
  parameter int         DATA_W   = 8,
  parameter int         DIGITS   = 2,
  parameter logic [7:0] SEP_CHAR = 8'h2C,
  parameter bit         CRLF     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic                     i_tx_full,
  output logic                     o_tx_push,
  output logic [7:0]               o_tx_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_ovf,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VALID = 3'd1,
    LATCH      = 3'd2,
    CONV       = 3'd3,
    EMIT_DIG   = 3'd4,
    EMIT_SEP   = 3'd5,
    EMIT_EOL   = 3'd6,
    DONE       = 3'd7
  } state_t;

  localparam int               BCD_W    = 4 * DIGITS;
  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [2:0]       LAST_DIG = 3'(DIGITS - 1);
  localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

  state_t                    state, state_nx;
  logic [NUM_CH*DATA_W-1:0]  snap;
  logic [2:0]                ch;
  logic [BIT_W-1:0]          bit_cnt;
  logic [2:0]                dig_cnt;
  logic [BCD_W-1:0]          bcd, bcd_adj, bcd_shift;
  logic                      ch_ovf;
  logic                      eol_cnt;
  logic [DATA_W-1:0]         chan_val;
  logic                      bit_in;
  logic                      conv_carry;
  logic                      can_issue;
  logic                      issue;
  logic [7:0]                tx_byte;
  logic [7:0]                digit_byte;
  logic                      cr_pending;

  assign dbg_state = state;

  // Binary-to-BCD step: add 3 to every digit >= 5, then shift the next binary bit in.
  // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
  assign chan_val   = DATA_W'(snap >> (int'(ch) * DATA_W));
  assign bit_in     = chan_val[LAST_BIT - bit_cnt];
  assign bcd_shift  = {bcd_adj[BCD_W-2:0], bit_in};
  assign conv_carry = bcd_adj[BCD_W-1];

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // A byte may only be issued when the FIFO reports space and the previous cycle did not push.
  assign can_issue  = !i_tx_full && !o_tx_push;
  assign digit_byte = ch_ovf ? 8'h39 : {4'h3, bcd[BCD_W-1 -: 4]};
  assign cr_pending = CRLF && !eol_cnt;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      IDLE:       if (i_start) state_nx = WAIT_VALID;
      WAIT_VALID: if (i_valid) state_nx = LATCH;
      LATCH:      state_nx = CONV;
      CONV:       if (bit_cnt == LAST_BIT) state_nx = EMIT_DIG;
      EMIT_DIG: begin
        tx_byte = digit_byte;
        if (can_issue) begin
          issue = 1'b1;
          if (dig_cnt == LAST_DIG) state_nx = (ch == LAST_CH) ? EMIT_EOL : EMIT_SEP;
        end
      end
      EMIT_SEP: begin
        tx_byte = SEP_CHAR;
        if (can_issue) begin
          issue    = 1'b1;
          state_nx = CONV;
        end
      end
      EMIT_EOL: begin
        tx_byte = cr_pending ? 8'h0D : 8'h0A;
        if (can_issue) begin
          issue = 1'b1;
          if (!cr_pending) state_nx = DONE;
        end
      end
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_tx_push <= 1'b0;
      o_tx_data <= 8'h00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_ovf     <= 1'b0;
      snap      <= '0;
      ch        <= 3'd0;
      bit_cnt   <= '0;
      dig_cnt   <= 3'd0;
      bcd       <= '0;
      ch_ovf    <= 1'b0;
      eol_cnt   <= 1'b0;
    end else begin
      o_tx_push <= issue;
      o_done    <= 1'b0;
      if (issue) o_tx_data <= tx_byte;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            o_ovf  <= 1'b0;
          end
        end
        // Snapshot is taken on the edge where valid is observed, so the frame never sees later data.
        WAIT_VALID: if (i_valid) snap <= i_data;
        LATCH: begin
          ch      <= 3'd0;
          bit_cnt <= '0;
          bcd     <= '0;
          ch_ovf  <= 1'b0;
          eol_cnt <= 1'b0;
        end
        CONV: begin
          bcd <= bcd_shift;
          if (conv_carry) begin
            ch_ovf <= 1'b1;
            o_ovf  <= 1'b1;
          end
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            dig_cnt <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        EMIT_DIG: begin
          if (issue) begin
            bcd     <= bcd << 4;
            dig_cnt <= dig_cnt + 3'd1;
          end
        end
        EMIT_SEP: begin
          if (issue) begin
            ch      <= ch + 3'd1;
            bit_cnt <= '0;
            bcd     <= '0;
            ch_ovf  <= 1'b0;
          end
        end
        EMIT_EOL: if (issue) eol_cnt <= 1'b1;
        DONE: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          eol_cnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_frame_sender.sv
// Bench for ascii_frame_sender: a default instance and a 3x16-bit, 5-digit, CRLF instance,
// with a byte scoreboard fed from a reference formatter and a monitor on both push streams.
module tb_ascii_frame_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        i_start = 1'b0, i_valid = 1'b0, i_tx_full = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_tx_push, o_busy, o_done, o_ovf;
  logic [7:0]  o_tx_data;
  logic [2:0]  dbg_state;

  logic        start5 = 1'b0, valid5 = 1'b0, full5 = 1'b0;
  logic [47:0] data5 = '0;
  logic        push5, busy5, done5, ovf5;
  logic [7:0]  txd5;
  logic [2:0]  state5;

  int n_cmp = 0, n_err = 0;
  int push_cnt = 0, done_cnt = 0, push5_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp5_q[$];

  always #5 clk = ~clk;

  ascii_frame_sender dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .i_tx_full(i_tx_full), .o_tx_push(o_tx_push), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf), .dbg_state(dbg_state)
  );

  ascii_frame_sender #(.NUM_CH(3), .DATA_W(16), .DIGITS(5), .CRLF(1'b1)) dut5 (
    .clk(clk), .rst(rst), .i_start(start5), .i_valid(valid5), .i_data(data5),
    .i_tx_full(full5), .o_tx_push(push5), .o_tx_data(txd5),
    .o_busy(busy5), .o_done(done5), .o_ovf(ovf5), .dbg_state(state5)
  );

  // Reference formatter: fixed-width decimal, all '9' when out of range.
  function automatic void model_frame(input bit sel, input int nch, input int digits,
                                      input bit crlf, input int v[8]);
    int lim, p;
    logic [7:0] b;
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    lim = lim - 1;
    for (int c = 0; c < nch; c++) begin
      if (c > 0) begin
        if (sel) exp5_q.push_back(8'h2C); else exp_q.push_back(8'h2C);
      end
      for (int d = digits - 1; d >= 0; d--) begin
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        b = (v[c] > lim) ? 8'h39 : 8'((v[c] / p) % 10 + 48);
        if (sel) exp5_q.push_back(b); else exp_q.push_back(b);
      end
    end
    if (crlf) begin
      if (sel) exp5_q.push_back(8'h0D); else exp_q.push_back(8'h0D);
    end
    if (sel) exp5_q.push_back(8'h0A); else exp_q.push_back(8'h0A);
  endfunction

  task automatic monitor();
    logic [7:0] e;
    bit push_prev = 0, full_prev = 0, push5_prev = 0, full5_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        push_prev = 0; full_prev = 0; push5_prev = 0; full5_prev = 0;
      end else begin
        if (o_tx_push) begin
          push_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL byte_unexpected: got %h with queue empty, want no push", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            if (o_tx_data !== e) begin
              n_err++;
              $display("FAIL byte: got %h, want %h", o_tx_data, e);
            end
          end
          n_cmp++;
          if (push_prev) begin n_err++; $display("FAIL push_spacing: got back-to-back pushes, want idle gap"); end
          n_cmp++;
          if (full_prev) begin n_err++; $display("FAIL push_while_full: got push issued while full=1, want none"); end
        end
        if (o_done) done_cnt++;
        if (push5) begin
          push5_cnt++;
          n_cmp++;
          if (exp5_q.size() == 0) begin
            n_err++;
            $display("FAIL byte5_unexpected: got %h with queue empty, want no push", txd5);
          end else begin
            e = exp5_q.pop_front();
            if (txd5 !== e) begin
              n_err++;
              $display("FAIL byte5: got %h, want %h", txd5, e);
            end
          end
          n_cmp++;
          if (push5_prev) begin n_err++; $display("FAIL push5_spacing: got back-to-back pushes, want idle gap"); end
          n_cmp++;
          if (full5_prev) begin n_err++; $display("FAIL push5_while_full: got push issued while full=1, want none"); end
        end
        push_prev = o_tx_push; full_prev = i_tx_full;
        push5_prev = push5;    full5_prev = full5;
      end
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start5 = 1'b1; else i_start = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0; i_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input bit jitter, input string name);
    bit seen = 0;
    int qsize;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (jitter) i_tx_full = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if ((sel ? done5 : o_done) === 1'b1) begin seen = 1; break; end
    end
    i_tx_full = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done_timeout: got no o_done in 600 cycles, want one pulse", name);
    end else begin
      qsize = sel ? exp5_q.size() : exp_q.size();
      n_cmp++;
      if (qsize != 0) begin
        n_err++;
        $display("FAIL %s_bytes_at_done: got %0d bytes outstanding, want 0", name, qsize);
      end
    end
  endtask

  task automatic run_frame(input int v0, input int v1, input bit jitter, input string name);
    int v[8];
    bit exp_ovf;
    v = '{default: 0};
    v[0] = v0; v[1] = v1;
    exp_ovf = (v0 > 99) || (v1 > 99);
    model_frame(0, 2, 2, 0, v);
    push_cnt = 0; done_cnt = 0;
    i_data = {8'(v1), 8'(v0)};
    i_valid = 1'b1;
    pulse_start(0);
    wait_done(0, jitter, name);
    @(negedge clk);
    n_cmp++;
    if (push_cnt != 6) begin n_err++; $display("FAIL %s_push_count: got %0d, want 6", name, push_cnt); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL %s_done_count: got %0d, want 1", name, done_cnt); end
    n_cmp++;
    if (o_ovf !== exp_ovf) begin n_err++; $display("FAIL %s_ovf: got %b, want %b", name, o_ovf, exp_ovf); end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after: got %b, want 0", name, o_busy); end
  endtask

  task automatic test_reset();
    int v[8];
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_tx_push !== 1'b0) begin n_err++; $display("FAIL rst_push: got %b, want 0", o_tx_push); end
    n_cmp++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, want 00", o_tx_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, want 0", o_done); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b, want 0", o_ovf); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d, want 0", dbg_state); end
    n_cmp++; if (busy5 !== 1'b0 || push5 !== 1'b0) begin n_err++; $display("FAIL rst_dut5: got busy=%b push=%b, want 0 0", busy5, push5); end
    // Start raised together with reset release lands on the first edge after reset.
    @(posedge clk); #1;
    rst = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL first_start_busy: got %b, want 1", o_busy); end
    n_cmp++; if (dbg_state !== 3'd1) begin n_err++; $display("FAIL first_start_state: got %0d, want 1", dbg_state); end
    v = '{default: 0};
    v[0] = 4; v[1] = 30;
    model_frame(0, 2, 2, 0, v);
    i_data = {8'd30, 8'd4};
    i_valid = 1'b1;
    wait_done(0, 0, "first_frame");
  endtask

  task automatic test_basic();
    run_frame(45, 23, 0, "basic");
    run_frame(123, 7, 0, "ovf");
    repeat (5) @(negedge clk);
    n_cmp++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, want 1", o_ovf); end
    i_valid = 1'b0;
    pulse_start(0);
    @(negedge clk);
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_start: got %b, want 0", o_ovf); end
    // Let the waiting frame finish with in-range values.
    begin
      int v[8];
      v = '{default: 0};
      v[0] = 20; v[1] = 10;
      model_frame(0, 2, 2, 0, v);
      i_data = {8'd10, 8'd20};
      i_valid = 1'b1;
      wait_done(0, 0, "ovf_clear_frame");
    end
  endtask

  task automatic test_boundaries();
    run_frame(99, 100, 0, "edge_99_100");
    run_frame(0, 255, 0, "edge_0_255");
    run_frame(9, 10, 0, "edge_9_10");
  endtask

  task automatic test_full_stall();
    int v[8];
    int held;
    bit reached = 0;
    v = '{default: 0};
    v[0] = 12; v[1] = 88;
    model_frame(0, 2, 2, 0, v);
    push_cnt = 0;
    i_data = {8'd88, 8'd12};
    i_valid = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (push_cnt >= 2) begin reached = 1; break; end
    end
    n_cmp++;
    if (!reached) begin n_err++; $display("FAIL stall_reach: got %0d pushes, want 2 before stall", push_cnt); end
    @(posedge clk); #1;
    i_tx_full = 1'b1; i_data = 16'hFFFF; i_valid = 1'b0;
    repeat (2) @(negedge clk);
    held = push_cnt;
    repeat (18) @(negedge clk);
    n_cmp++; if (push_cnt != held) begin n_err++; $display("FAIL stall_no_push: got %0d pushes, want %0d", push_cnt, held); end
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b, want 1", o_busy); end
    @(posedge clk); #1;
    i_tx_full = 1'b0;
    wait_done(0, 0, "stall");
    @(negedge clk);
    n_cmp++; if (push_cnt != 6) begin n_err++; $display("FAIL stall_push_count: got %0d, want 6", push_cnt); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL stall_ovf: got %b, want 0", o_ovf); end
  endtask

  task automatic test_ignored_start();
    int v[8];
    bit found = 0;
    v = '{default: 0};
    v[0] = 1; v[1] = 2;
    model_frame(0, 2, 2, 0, v);
    push_cnt = 0; done_cnt = 0;
    i_valid = 1'b0;
    i_data = {8'd2, 8'd1};
    pulse_start(0);
    repeat (40) @(posedge clk);
    pulse_start(0);
    repeat (58) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (push_cnt != 0) begin n_err++; $display("FAIL wait_valid_push: got %0d, want 0", push_cnt); end
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL wait_valid_busy: got %b, want 1", o_busy); end
    n_cmp++; if (dbg_state !== 3'd1) begin n_err++; $display("FAIL wait_valid_state: got %0d, want 1", dbg_state); end
    @(posedge clk); #1;
    i_valid = 1'b1;
    repeat (10) @(posedge clk);
    pulse_start(0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dbg_state === 3'd7) begin found = 1; break; end
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_cmp++; if (!found) begin n_err++; $display("FAIL done_state_timeout: got no DONE state, want one"); end
    repeat (40) @(negedge clk);
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d, want 1", done_cnt); end
    n_cmp++; if (push_cnt != 6) begin n_err++; $display("FAIL ignore_push_count: got %0d, want 6", push_cnt); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL ignore_idle: got %0d, want 0", dbg_state); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ignore_leftover: got %0d bytes left, want 0", exp_q.size()); end
    i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int v[8];
    bit reached = 0;
    v = '{default: 0};
    v[0] = 66; v[1] = 55;
    model_frame(0, 2, 2, 0, v);
    push_cnt = 0;
    i_data = {8'd55, 8'd66};
    i_valid = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (push_cnt == 3) begin reached = 1; break; end
    end
    n_cmp++; if (!reached) begin n_err++; $display("FAIL midrst_reach: got %0d pushes, want 3", push_cnt); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_tx_push !== 1'b0) begin n_err++; $display("FAIL midrst_push: got %b, want 0", o_tx_push); end
    n_cmp++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h, want 00", o_tx_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, want 0", o_busy); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL midrst_state: got %0d, want 0", dbg_state); end
    n_cmp++; if (exp_q.size() != 3) begin n_err++; $display("FAIL midrst_partial: got %0d bytes left, want 3", exp_q.size()); end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (push_cnt != 3) begin n_err++; $display("FAIL midrst_no_resume: got %0d pushes, want 3", push_cnt); end
    run_frame(9, 100, 0, "after_reset");
  endtask

  task automatic test_wide();
    int v[8];
    v = '{default: 0};
    v[0] = 65535; v[1] = 0; v[2] = 1024;
    model_frame(1, 3, 5, 1, v);
    push5_cnt = 0;
    data5 = {16'd1024, 16'd0, 16'd65535};
    valid5 = 1'b1;
    pulse_start(1);
    wait_done(1, 0, "wide");
    @(negedge clk);
    n_cmp++; if (push5_cnt != 19) begin n_err++; $display("FAIL wide_push_count: got %0d, want 19", push5_cnt); end
    n_cmp++; if (ovf5 !== 1'b0) begin n_err++; $display("FAIL wide_ovf: got %b, want 0", ovf5); end
    v[0] = $urandom_range(0, 65535); v[1] = $urandom_range(0, 9); v[2] = $urandom_range(10000, 65535);
    model_frame(1, 3, 5, 1, v);
    data5 = {16'(v[2]), 16'(v[1]), 16'(v[0])};
    pulse_start(1);
    wait_done(1, 0, "wide_rand");
    valid5 = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_frame($urandom_range(0, 255), $urandom_range(0, 255), 1'b1, "random");
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_boundaries();
    test_full_stall();
    test_ignored_start();
    test_reset_mid();
    test_wide();
    test_random();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascii_frame_sender.md
ASCII_FRAME_SENDER -- requirements
Module: ascii_frame_sender

Interface
REQ-001 Parameter NUM_CH, default 2, number of data channels per frame (1..8).
REQ-002 Parameter DATA_W, default 8, bits per channel value (4..16, unsigned).
REQ-003 Parameter DIGITS, default 2, decimal digits emitted per channel (1..5).
REQ-004 Parameter SEP_CHAR, default 8'h2C (','), byte emitted between channels.
REQ-005 Parameter CRLF, default 0, line ending: 0 -> 8'h0A only; 1 -> 8'h0D then 8'h0A.
REQ-006 Port clk  input  1  system clock; all logic on its rising edge.
REQ-007 Port rst  input  1  reset; synchronous, active-low.
REQ-008 Port i_start  input  1  single-cycle frame request, already debounced.
REQ-009 Port i_valid  input  1  level; i_data is stable and valid while high.
REQ-010 Port i_data  input  NUM_CH*DATA_W  channel values; channel 0 in LSBs, sent first.
REQ-011 Port i_tx_full  input  1  downstream TX FIFO full flag.
REQ-012 Port o_tx_push  output  1  registered one-cycle write strobe to TX FIFO.
REQ-013 Port o_tx_data  output  8  registered byte, valid when o_tx_push=1.
REQ-014 Port o_busy  output  1  high from frame acceptance until last byte pushed.
REQ-015 Port o_done  output  1  one-cycle pulse the cycle after the last byte push.
REQ-016 Port o_ovf  output  1  sticky per frame: some channel exceeded 10^DIGITS-1.

Function
REQ-017 States SHALL be IDLE, WAIT_VALID, LATCH, CONV, EMIT_DIG, EMIT_SEP, EMIT_EOL, DONE.
REQ-018 IDLE: i_start=1 -> WAIT_VALID, o_busy=1, o_ovf cleared; i_start in any other state SHALL be ignored.
REQ-019 WAIT_VALID: waits indefinitely; i_valid=1 -> LATCH.
REQ-020 LATCH: captures all of i_data in one cycle into an internal snapshot; later i_data changes do not affect the frame; channel index=0 -> CONV.
REQ-021 CONV: sequential binary-to-BCD (shift-add-3), exactly DATA_W cycles per channel, no divider/modulo operators.
REQ-022 Value > 10^DIGITS-1: every digit of that channel SHALL be '9' (8'h39) and o_ovf set; no truncation.
REQ-023 Digits emitted most-significant first, zero-padded to exactly DIGITS bytes (7 with DIGITS=2 -> "07"); byte = digit + 8'h30.
REQ-024 After a channel's digits: channel < NUM_CH-1 -> EMIT_SEP (SEP_CHAR), index+1, back to CONV; else EMIT_EOL.
REQ-025 EMIT_EOL: emits 8'h0A, or 8'h0D then 8'h0A when CRLF=1, then DONE.
REQ-026 DONE: o_done=1 for one cycle, o_busy=0, -> IDLE; i_start in the DONE cycle ignored.
REQ-027 Push rule: a byte is issued only if i_tx_full sampled 0 in the issuing cycle; o_tx_push asserts the following cycle.
REQ-028 Pushes SHALL never occur on consecutive cycles (minimum one idle cycle between pushes) so full-flag updates are seen.
REQ-029 i_tx_full=1: FSM holds state and pending byte; no byte lost, duplicated or reordered.
REQ-030 Frame length = NUM_CH*DIGITS + (NUM_CH-1) + 1 + CRLF bytes exactly.
REQ-031 o_tx_data SHALL hold its last value when o_tx_push=0.

Reset
REQ-032 rst=0 at a clock edge: state IDLE, o_tx_push=0, o_tx_data=0, o_busy=0, o_done=0, o_ovf=0, snapshot and counters 0.
REQ-033 Reset mid-frame aborts immediately; no further bytes pushed; partial frame is not resumed.
REQ-034 First i_start honoured is on the first edge after rst returns high.

Verification
REQ-035 Defaults, i_data={8'd23,8'd45}, start, i_valid=1 -> bytes "45,23" 8'h0A, 6 pushes, o_done once, o_ovf=0.
REQ-036 DIGITS=2, channel 0=8'd123, channel 1=8'd7 -> "99,07" 8'h0A, o_ovf=1 until next start.
REQ-037 NUM_CH=3, DATA_W=16, DIGITS=5, CRLF=1, values 65535,0,1024 -> "65535,00000,01024" 8'h0D 8'h0A.
REQ-038 i_tx_full held high 20 cycles mid-frame, i_data changed meanwhile -> no push while full, sequence intact, snapshot values sent.
REQ-039 i_start pulsed while o_busy=1 and during DONE -> exactly one frame sent; delayed i_valid (100 cycles) -> frame starts after it.
REQ-040 rst=0 after third byte -> outputs at reset values next cycle, no further pushes; new start sends a complete frame.
